// File: rtl/fp_result_checker_if.sv
// Bundle of the handshake and status signals between an FP result checker and
// whatever drives it (bench or self-test sequencer).
//   master : drives start/expected/result/result_valid, observes status
//   slave  : the checker itself
// Handshake: start is a one-cycle request that the checker takes only while
// idle (busy=0, done=0); result_valid is a one-cycle strobe that the checker
// takes only while waiting; done is a one-cycle completion pulse, and pass and
// timed_out are valid from that cycle until the next done.
interface fp_result_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      expected;
  logic [31:0]      result;
  logic             result_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timed_out;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [CNT_W-1:0] tmo_count;

  modport master (
    output start, expected, result, result_valid,
    input  busy, done, pass, timed_out, pass_count, fail_count, tmo_count
  );

  modport slave (
    input  start, expected, result, result_valid,
    output busy, done, pass, timed_out, pass_count, fail_count, tmo_count
  );
endinterface

// File: rtl/fp_result_checker.sv
// Waits for one single-precision FPU result after start, compares it against
// the latched expected word with a ULP tolerance and NaN/Inf/zero special
// cases, and keeps saturating pass/fail/timeout tallies.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp_result_checker_if.slave (start/expected/result/result_valid
//                in; busy/done/pass/timed_out/pass_count/fail_count/tmo_count out)
//   state_dbg  : current FSM state (0 idle, 1 wait, 2 cmp, 3 report)
module fp_result_checker #(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int ULP_TOL         = 1,
  parameter int ZERO_SIGN_EXACT = 0,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_result_checker_if.slave  bus,
  output logic [1:0]          state_dbg
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_CMP    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t           state, state_n;
  logic             tmo_hit;
  logic [31:0]      exp_q, res_q;
  logic [TMR_W-1:0] tmr;
  logic             pass_q, tmo_q;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, tmo_cnt;

  // ---------------- compare of the latched pair ----------------
  logic        e_nan, r_nan, e_inf, r_inf, e_zero, r_zero;
  logic [32:0] mag_e, mag_r, ord_e, ord_r;
  logic [33:0] diff, adiff;
  logic        match;

  assign e_nan  = (&exp_q[30:23]) && (|exp_q[22:0]);
  assign r_nan  = (&res_q[30:23]) && (|res_q[22:0]);
  assign e_inf  = (&exp_q[30:23]) && !(|exp_q[22:0]);
  assign r_inf  = (&res_q[30:23]) && !(|res_q[22:0]);
  assign e_zero = (exp_q[30:0] == 31'd0);
  assign r_zero = (res_q[30:0] == 31'd0);

  // Sign-magnitude to two's-complement ordinal: adjacent floats differ by 1,
  // and the 34-bit difference cannot overflow.
  assign mag_e = {2'b00, exp_q[30:0]};
  assign mag_r = {2'b00, res_q[30:0]};
  assign ord_e = exp_q[31] ? (33'd0 - mag_e) : mag_e;
  assign ord_r = res_q[31] ? (33'd0 - mag_r) : mag_r;
  assign diff  = {ord_r[32], ord_r} - {ord_e[32], ord_e};
  assign adiff = diff[33] ? (34'd0 - diff) : diff;

  always_comb begin
    match = 1'b0;
    if (e_nan || r_nan)
      match = e_nan && r_nan;
    else if (e_inf || r_inf)
      match = (exp_q == res_q);
    else if (e_zero && r_zero)
      match = (ZERO_SIGN_EXACT != 0) ? (exp_q == res_q) : 1'b1;
    else
      match = (adiff <= 34'(ULP_TOL));
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    tmo_hit = 1'b0;
    case (state)
      S_IDLE:   if (bus.start) state_n = S_WAIT;
      S_WAIT: begin
        // A result arriving on the last timer cycle still counts as a result.
        if (bus.result_valid) begin
          state_n = S_CMP;
        end else if (tmr == TMR_LAST) begin
          state_n = S_REPORT;
          tmo_hit = 1'b1;
        end
      end
      S_CMP:    state_n = S_REPORT;
      S_REPORT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // ---------------- datapath / verdict / tallies ----------------
  // Verdict and counters are written on entry to REPORT so they are already
  // valid in the cycle done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q    <= '0;
      res_q    <= '0;
      tmr      <= '0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            exp_q <= bus.expected;
            tmr   <= '0;
          end
        end
        S_WAIT: begin
          if (bus.result_valid) begin
            res_q <= bus.result;
          end else if (tmo_hit) begin
            pass_q <= 1'b0;
            tmo_q  <= 1'b1;
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_CMP: begin
          pass_q <= match;
          tmo_q  <= 1'b0;
          if (match) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state == S_WAIT) || (state == S_CMP);
  assign bus.done       = (state == S_REPORT);
  assign bus.pass       = pass_q;
  assign bus.timed_out  = tmo_q;
  assign bus.pass_count = pass_cnt;
  assign bus.fail_count = fail_cnt;
  assign bus.tmo_count  = tmo_cnt;
  assign state_dbg      = state;

endmodule

// File: tb/tb_fp_result_checker.sv
module tb_fp_result_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters. Instance B: exact zero sign, 2-bit counters.
  fp_result_checker_if #(.CNT_W(16)) ifa ();
  fp_result_checker_if #(.CNT_W(2))  ifb ();
  logic [1:0] st_a, st_b;

  fp_result_checker #(.TIMEOUT_CYCLES(16), .ULP_TOL(1), .ZERO_SIGN_EXACT(0), .CNT_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa), .state_dbg(st_a));
  fp_result_checker #(.TIMEOUT_CYCLES(16), .ULP_TOL(1), .ZERO_SIGN_EXACT(1), .CNT_W(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb), .state_dbg(st_b));

  // Both instances see identical stimulus.
  assign ifb.start        = ifa.start;
  assign ifb.expected     = ifa.expected;
  assign ifb.result       = ifa.result;
  assign ifb.result_valid = ifa.result_valid;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int m_pa, m_fa, m_ta;   // model counters, instance A
  int m_pb, m_fb, m_tb;   // model counters, instance B (saturate at 3)

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_pa = 0; m_fa = 0; m_ta = 0;
    m_pb = 0; m_fb = 0; m_tb = 0;
  endtask

  task automatic model_update(input logic tmo, input logic pa, input logic pb);
    if (tmo) begin
      m_ta++;
      if (m_tb < 3) m_tb++;
    end else begin
      if (pa) m_pa++; else m_fa++;
      if (pb) begin if (m_pb < 3) m_pb++; end
      else    begin if (m_fb < 3) m_fb++; end
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, " pass_count_a"}, 64'(ifa.pass_count), 64'(m_pa));
    check({tag, " fail_count_a"}, 64'(ifa.fail_count), 64'(m_fa));
    check({tag, " tmo_count_a"},  64'(ifa.tmo_count),  64'(m_ta));
    check({tag, " pass_count_b"}, 64'(ifb.pass_count), 64'(m_pb));
    check({tag, " fail_count_b"}, 64'(ifb.fail_count), 64'(m_fb));
    check({tag, " tmo_count_b"},  64'(ifb.tmo_count),  64'(m_tb));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start in the current cycle, raise result_valid in cycle start+k
  // (k=0: never) and return the cycle offset at which done was seen (-1: none).
  task automatic run_check(input logic [31:0] e, input logic [31:0] r, input int k,
                           output int lat);
    lat = -1;
    ifa.start = 1'b1;
    ifa.expected = e;
    ifa.result = r;
    for (int n = 1; n <= 40; n++) begin
      tick();
      ifa.start = 1'b0;
      ifa.result_valid = 1'b0;
      if (ifa.done) begin
        lat = n;
        break;
      end
      ifa.result_valid = (n == k);
    end
    ifa.result_valid = 1'b0;
  endtask

  task automatic check_done(input string tag, input int lat, input int lat_exp,
                            input logic tmo, input logic pa, input logic pb);
    check({tag, " latency"},     64'(lat),           64'(lat_exp));
    check({tag, " pass_a"},      64'(ifa.pass),      64'(pa));
    check({tag, " pass_b"},      64'(ifb.pass),      64'(pb));
    check({tag, " timed_out_a"}, 64'(ifa.timed_out), 64'(tmo));
    check({tag, " timed_out_b"}, 64'(ifb.timed_out), 64'(tmo));
    check({tag, " done_b"},      64'(ifb.done),      64'(1));
    model_update(tmo, pa, pb);
    check_counters(tag);
    tick();  // REPORT -> IDLE
    check({tag, " idle after"}, 64'(st_a), 64'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] e;
    logic [31:0] r;
    int          k;    // cycle of result_valid after start; 0 = never
    logic        pa;   // expected verdict, ZERO_SIGN_EXACT=0
    logic        pb;   // expected verdict, ZERO_SIGN_EXACT=1
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    string tag;

    vecs[0]  = '{32'h412DED91, 32'h412DED91, 3, 1'b1, 1'b1}; // add, exact
    vecs[1]  = '{32'h3A378000, 32'h3A378001, 1, 1'b1, 1'b1}; // sub, 1 ULP
    vecs[2]  = '{32'h3A378000, 32'h3A378002, 2, 1'b0, 1'b0}; // sub, 2 ULP
    vecs[3]  = '{32'h7FC00000, 32'hFFC00001, 1, 1'b1, 1'b1}; // both NaN
    vecs[4]  = '{32'h7F800000, 32'h7F7FFFFF, 1, 1'b0, 1'b0}; // Inf vs max finite
    vecs[5]  = '{32'h00000000, 32'h80000000, 1, 1'b1, 1'b0}; // +0 vs -0
    vecs[6]  = '{32'h00000001, 32'h80000001, 2, 1'b0, 1'b0}; // +/- min denormal, 2 ULP
    vecs[7]  = '{32'h3F800000, 32'h3F7FFFFF, 4, 1'b1, 1'b1}; // across exponent
    vecs[8]  = '{32'hBF800000, 32'hBF800001, 1, 1'b1, 1'b1}; // negative, 1 ULP
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1, 1'b0, 1'b0}; // one NaN
    vecs[10] = '{32'hFF800000, 32'hFF800000, 2, 1'b1, 1'b1}; // identical -Inf
    vecs[11] = '{32'h3F800000, 32'h3F800000, 0, 1'b0, 1'b0}; // timeout
    vecs[12] = '{32'h80000000, 32'h80000000, 1, 1'b1, 1'b1}; // -0 vs -0
    vecs[13] = '{32'h00000000, 32'h00000001, 1, 1'b1, 1'b1}; // zero vs min denormal

    ifa.start = 1'b0;
    ifa.expected = '0;
    ifa.result = '0;
    ifa.result_valid = 1'b0;
    model_clear();

    // reset state
    repeat (3) tick();
    check("reset busy",  64'(ifa.busy),  64'(0));
    check("reset done",  64'(ifa.done),  64'(0));
    check("reset pass",  64'(ifa.pass),  64'(0));
    check("reset tmo",   64'(ifa.timed_out), 64'(0));
    check("reset state", 64'(st_a), 64'(0));
    check_counters("reset");
    rst_n = 1'b1;
    tick();

    // result_valid while idle is ignored
    ifa.result_valid = 1'b1;
    tick();
    tick();
    ifa.result_valid = 1'b0;
    check("idle rv state", 64'(st_a), 64'(0));
    check("idle rv busy",  64'(ifa.busy), 64'(0));

    // table
    for (int i = 0; i < 14; i++) begin
      tag = $sformatf("vec%0d", i);
      run_check(vecs[i].e, vecs[i].r, vecs[i].k, lat);
      check_done(tag, lat, (vecs[i].k == 0) ? 17 : vecs[i].k + 2,
                 vecs[i].k == 0, vecs[i].pa, vecs[i].pb);
    end

    // result_valid on the timer's last cycle wins over the timeout
    run_check(32'h41200000, 32'h41200000, 16, lat);
    check_done("rv on timeout", lat, 18, 1'b0, 1'b1, 1'b1);

    // start while busy is ignored; the first expected word is kept
    begin
      lat = -1;
      ifa.start = 1'b1;
      ifa.expected = 32'h40000000;
      ifa.result = 32'h40000000;
      for (int n = 1; n <= 40; n++) begin
        tick();
        ifa.start = 1'b0;
        ifa.result_valid = 1'b0;
        if (ifa.done) begin
          lat = n;
          break;
        end
        if (n == 2) begin
          check("busy mid-wait", 64'(ifa.busy), 64'(1));
          ifa.start = 1'b1;
          ifa.expected = 32'h7F800000;
        end
        ifa.result_valid = (n == 4);
      end
      ifa.result_valid = 1'b0;
      check_done("start while busy", lat, 6, 1'b0, 1'b1, 1'b1);
    end

    // asynchronous reset in the middle of WAIT
    ifa.start = 1'b1;
    ifa.expected = 32'h3F800000;
    tick();
    ifa.start = 1'b0;
    tick();
    tick();
    check("pre-reset state", 64'(st_a), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("async rst state", 64'(st_a), 64'(0));
    check("async rst busy",  64'(ifa.busy), 64'(0));
    check("async rst pass",  64'(ifa.pass), 64'(0));
    check("async rst tmo",   64'(ifa.timed_out), 64'(0));
    check_counters("async rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // saturation of 2-bit counters after five passes
    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("sat%0d", i);
      run_check(32'h3F800000, 32'h3F800000, 1, lat);
      check_done(tag, lat, 3, 1'b0, 1'b1, 1'b1);
    end
    check("sat pass_count_b", 64'(ifb.pass_count), 64'(3));
    check("sat pass_count_a", 64'(ifa.pass_count), 64'(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
